// File: rtl/regfile_write_demux.sv
// regfile_write_demux: 31 x N-bit ARM register file (X0-X30) with a 1-to-32
// one-hot write demultiplexer and two combinational read ports.
// Address 31 is XZR: it has no storage and always reads as zero.
// A write that matches a read address is forwarded in the same cycle.
module regfile_write_demux #(
  parameter int N = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [4:0]    i_wr_addr,
  input  logic [N-1:0]  i_wr_data,
  input  logic [4:0]    i_rd_addr1,
  input  logic [4:0]    i_rd_addr2,
  output logic [N-1:0]  o_rd_data1,
  output logic [N-1:0]  o_rd_data2,
  output logic [31:0]   o_wr_sel
);

  localparam logic [4:0] XZR_ADDR = 5'd31;

  // One-hot write enables, one bit per architectural address.
  logic [31:0]  w_wr_sel;
  // Stored register contents; entry 31 is a constant zero so the read mux
  // can index the full 5-bit address range without an out-of-range access.
  logic [N-1:0] w_regs [32];

  // Per-port forwarding qualifiers.
  logic         w_fwd1;
  logic         w_fwd2;

  // ------------------------------------------------------------------
  // Write decoder: bit k asserts only when a write targets address k.
  // Bit 31 is allowed to assert; nothing consumes it for storage.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_dec
      assign w_wr_sel[gi] = i_wr_en && (i_wr_addr == 5'(gi));
    end
  endgenerate

  assign o_wr_sel = w_wr_sel;

  // ------------------------------------------------------------------
  // Storage: X0-X30 each get their own flop bank with async clear.
  // Reset takes priority over the write enable, so a write that is in
  // flight when reset rises is dropped.
  // ------------------------------------------------------------------
  generate
    for (gi = 0; gi < 31; gi++) begin : g_reg
      logic [N-1:0] r_q;

      // Load WrData when this register is selected, otherwise hold.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_q <= '0;
        end else if (w_wr_sel[gi]) begin
          r_q <= i_wr_data;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  // XZR has no backing storage.
  assign w_regs[31] = '0;

  // ------------------------------------------------------------------
  // Read ports. Priority: XZR, then same-cycle forwarding, then storage.
  // Forwarding deliberately ignores reset: reads are combinational and
  // still reflect an active write request while reset is held.
  // ------------------------------------------------------------------
  assign w_fwd1 = i_wr_en && (i_wr_addr == i_rd_addr1);
  assign w_fwd2 = i_wr_en && (i_wr_addr == i_rd_addr2);

  // Read port 1 mux.
  always_comb begin
    o_rd_data1 = w_regs[i_rd_addr1];
    if (i_rd_addr1 == XZR_ADDR) begin
      o_rd_data1 = '0;
    end else if (w_fwd1) begin
      o_rd_data1 = i_wr_data;
    end
  end

  // Read port 2 mux.
  always_comb begin
    o_rd_data2 = w_regs[i_rd_addr2];
    if (i_rd_addr2 == XZR_ADDR) begin
      o_rd_data2 = '0;
    end else if (w_fwd2) begin
      o_rd_data2 = i_wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Testbench for regfile_write_demux: table-driven vectors plus hand-written
// sequences for reset and consecutive-write corner cases. Expected values are
// queued when stimulus is driven and popped when outputs are sampled.
module tb_regfile_write_demux;
  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [N-1:0]  wr_data;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic [N-1:0]  rd_data1;
  logic [N-1:0]  rd_data2;
  logic [31:0]   wr_sel;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [31:0]  sel;
    string        tag;
  } exp_t;

  typedef struct {
    logic         en;
    logic [4:0]   wa;
    logic [N-1:0] wd;
    logic [4:0]   ra1;
    logic [4:0]   ra2;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
    logic [31:0]  es;
    string        tag;
  } vec_t;

  exp_t          sb[$];
  vec_t          vecs[10];
  logic [N-1:0]  model [32];

  localparam logic [N-1:0] X5_VAL = 64'hDEAD_BEEF_0000_0005;

  regfile_write_demux #(.N(N)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_addr1 (rd_addr1),
    .i_rd_addr2 (rd_addr2),
    .o_rd_data1 (rd_data1),
    .o_rd_data2 (rd_data2),
    .o_wr_sel   (wr_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] wa, input logic [N-1:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    wr_en    = en;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr1 = ra1;
    rd_addr2 = ra2;
  endtask

  task automatic push_exp(input logic [N-1:0] e1, input logic [N-1:0] e2,
                          input logic [31:0] es, input string tag);
    exp_t e;
    e.rd1 = e1;
    e.rd2 = e2;
    e.sel = es;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_rd1"}, rd_data1, e.rd1);
      check({e.tag, "_rd2"}, rd_data2, e.rd2);
      check({e.tag, "_sel"}, {32'd0, wr_sel}, {32'd0, e.sel});
      $display("txn %s en=%0b wa=%0d wd=%h ra1=%0d ra2=%0d rd1=%h rd2=%h sel=%h",
               e.tag, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, rd_data1, rd_data2, wr_sel);
    end
  endtask

  // Reference read: XZR, then forward, then stored model value.
  function automatic logic [N-1:0] model_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  // Commit the current cycle: track the write in the model, then return to
  // the falling edge ready for the next drive.
  task automatic finish_cycle();
    @(posedge clk);
    if (wr_en && wr_addr != 5'd31 && !reset) model[wr_addr] = wr_data;
    @(negedge clk);
  endtask

  // One full transaction: drive at negedge, sample #1 later, then clock.
  task automatic step(input logic en, input logic [4:0] wa, input logic [N-1:0] wd,
                      input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [N-1:0] e1, input logic [N-1:0] e2,
                      input logic [31:0] es, input string tag);
    drive(en, wa, wd, ra1, ra2);
    push_exp(e1, e2, es, tag);
    #1;
    pop_compare();
    finish_cycle();
  endtask

  task automatic set_vec(input int i, input logic en, input logic [4:0] wa,
                         input logic [N-1:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [N-1:0] e1, input logic [N-1:0] e2,
                         input logic [31:0] es, input string tag);
    vecs[i].en = en;  vecs[i].wa = wa;  vecs[i].wd = wd;
    vecs[i].ra1 = ra1; vecs[i].ra2 = ra2;
    vecs[i].e1 = e1;  vecs[i].e2 = e2;  vecs[i].es = es;
    vecs[i].tag = tag;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Vector table: sequential, each row relies on the rows before it.
    set_vec(0, 1, 5'd5,  X5_VAL,  5'd5,  5'd6,  X5_VAL,   64'd0,    32'h0000_0020, "x5_fwd");
    set_vec(1, 0, 5'd5,  64'd0,   5'd5,  5'd31, X5_VAL,   64'd0,    32'h0000_0000, "x5_stored");
    set_vec(2, 1, 5'd31, '1,      5'd31, 5'd31, 64'd0,    64'd0,    32'h8000_0000, "xzr_write");
    set_vec(3, 0, 5'd31, '1,      5'd31, 5'd5,  64'd0,    X5_VAL,   32'h0000_0000, "xzr_after");
    set_vec(4, 1, 5'd3,  64'hA,   5'd3,  5'd3,  64'hA,    64'hA,    32'h0000_0008, "x3_a_fwd");
    set_vec(5, 1, 5'd3,  64'hB,   5'd3,  5'd3,  64'hB,    64'hB,    32'h0000_0008, "x3_b_fwd");
    set_vec(6, 0, 5'd3,  64'hC,   5'd3,  5'd3,  64'hB,    64'hB,    32'h0000_0000, "x3_last_wins");
    set_vec(7, 1, 5'd4,  64'h44,  5'd4,  5'd3,  64'h44,   64'hB,    32'h0000_0010, "x4_fwd_x3");
    set_vec(8, 0, 5'd5,  64'hFFFF,5'd5,  5'd4,  X5_VAL,   64'h44,   32'h0000_0000, "no_fwd_wren0");
    set_vec(9, 1, 5'd0,  64'h77,  5'd1,  5'd0,  64'd0,    64'h77,   32'h0000_0001, "x0_fwd_p2");

    repeat (2) @(negedge clk);

    // Reset state: all addresses read zero, no write select.
    step(0, 5'd0, '0, 5'd0, 5'd31, '0, '0, 32'd0, "reset_held");
    reset = 1'b0;
    for (int k = 0; k < 32; k++)
      step(0, 5'd0, '0, 5'(k), 5'(31 - k), '0, '0, 32'd0, $sformatf("reset_rd%0d", k));

    // Table-driven vectors.
    for (int i = 0; i < 10; i++)
      step(vecs[i].en, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2,
           vecs[i].e1, vecs[i].e2, vecs[i].es, vecs[i].tag);

    // Fill X0..X30 with (k+1)*0x0101; port 1 sees the forwarded write.
    for (int k = 0; k < 31; k++) begin
      drive(1'b1, 5'(k), 64'((k + 1) * 32'h0101), 5'(k), 5'(30 - k));
      push_exp(64'((k + 1) * 32'h0101), model_rd(5'(30 - k)), 32'd1 << k,
               $sformatf("fill%0d", k));
      #1;
      pop_compare();
      finish_cycle();
    end
    // Read back pairs (k, 30-k).
    for (int k = 0; k < 31; k++)
      step(0, 5'd31, '1, 5'(k), 5'(30 - k), 64'((k + 1) * 32'h0101),
           64'((31 - k) * 32'h0101), 32'd0, $sformatf("pair%0d", k));

    // Asynchronous reset between edges.
    step(1, 5'd7, 64'h1234, 5'd7, 5'd31, 64'h1234, '0, 32'h0000_0080, "x7_write");
    drive(1'b0, 5'd7, '0, 5'd7, 5'd8);
    #1;
    check("x7_before_reset", rd_data1, 64'h1234);
    check("x8_before_reset", rd_data2, 64'h0909);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    check("x7_async_clear", rd_data1, 64'd0);
    check("x8_async_clear", rd_data2, 64'd0);
    @(negedge clk);
    // Write while reset is high: forwarded combinationally, never stored.
    step(1, 5'd7, 64'h55, 5'd7, 5'd2, 64'h55, '0, 32'h0000_0080, "wr_in_reset");
    step(0, 5'd7, '0, 5'd7, 5'd2, '0, '0, 32'd0, "blocked_in_reset");
    reset = 1'b0;
    step(0, 5'd7, '0, 5'd7, 5'd30, '0, '0, 32'd0, "after_reset");
    step(1, 5'd7, 64'h99, 5'd30, 5'd7, '0, 64'h99, 32'h0000_0080, "first_write_post");
    step(0, 5'd7, '0, 5'd7, 5'd7, 64'h99, 64'h99, 32'd0, "first_write_stored");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
